// File: rtl/leaf_arb_pkg.sv
// Shared definitions for the leaf output-port arbiter.
// Contents: FSM state enum, index-width helper, default width constants.
package leaf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BUSY = 2'd2
    } arb_state_e;

    // Bits needed to index n items (at least 1).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_BURST_LEN = 16;
    localparam int unsigned DEF_GRANT_W   = idx_w(DEF_NUM_REQ);
    localparam int unsigned DEF_BEAT_W    = idx_w(DEF_BURST_LEN);
    localparam int unsigned BEAT_CNT_W    = 32;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request searching upward from
// (i_last_grant + 1) with wrap-around. Purely combinational.
// Ports:
//   i_req        requester valid vector
//   i_last_grant index granted last
//   o_found      any request asserted
//   o_index      selected requester
module rr_pick import leaf_arb_pkg::*; #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_index
);

    // Lowest request at or below last_grant is the wrap-around fallback;
    // the lowest request above last_grant overrides it.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (i_req[j] && (IDX_W'(j) <= i_last_grant)) begin
                o_found = 1'b1;
                o_index = IDX_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (i_req[j] && (IDX_W'(j) > i_last_grant)) begin
                o_found = 1'b1;
                o_index = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter sharing one leaf-interface output port among
// NUM_REQ user streams, granting bursts of up to BURST_LEN words.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   ap_start              enables arbitration
//   din / vld_in          packed requester data / valid
//   rdy_upward            per-requester ready (only owner sees rdy_downward)
//   dout / vld_out        data / valid toward the interface
//   rdy_downward          interface ready
//   grant_id / busy       current owner / grant held
//   beat_cnt              total transfers since reset (OUT_ARB_BEAT_CNT_EN only)
// Optional feature macro: OUT_ARB_BEAT_CNT_EN.
module out_port_arbiter import leaf_arb_pkg::*; #(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned BURST_LEN    = DEF_BURST_LEN
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            ap_start,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din,
    input  logic [NUM_REQ-1:0]              vld_in,
    output logic [NUM_REQ-1:0]              rdy_upward,
    output logic [PAYLOAD_BITS-1:0]         dout,
    output logic                            vld_out,
    input  logic                            rdy_downward,
    output logic [idx_w(NUM_REQ)-1:0]       grant_id,
    output logic                            busy
`ifdef OUT_ARB_BEAT_CNT_EN
    ,
    output logic [BEAT_CNT_W-1:0]           beat_cnt
`endif
);

    localparam int unsigned     IDX_W     = idx_w(NUM_REQ);
    localparam int unsigned     CNT_W     = idx_w(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_REQ  = IDX_W'(NUM_REQ - 1);

    arb_state_e              r_state, w_state_nxt;
    logic [IDX_W-1:0]        r_grant, w_grant_nxt;
    logic [IDX_W-1:0]        r_last, w_last_nxt;
    logic [CNT_W-1:0]        r_beat, w_beat_nxt;
    logic [PAYLOAD_BITS-1:0] r_dout_hold;
    logic [PAYLOAD_BITS-1:0] w_slice;
    logic                    w_vld_g;
    logic                    w_xfer;
    logic                    w_found;
    logic [IDX_W-1:0]        w_pick;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req        (vld_in),
        .i_last_grant (r_last),
        .o_found      (w_found),
        .o_index      (w_pick)
    );

    // Owner's data slice and valid.
    always_comb begin
        w_slice = '0;
        w_vld_g = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_slice = din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                w_vld_g = vld_in[i];
            end
        end
    end

    assign w_xfer   = (r_state == BUSY) && w_vld_g && rdy_downward;
    assign grant_id = r_grant;

    // Next state and the combinational datapath outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_beat_nxt  = r_beat;
        busy        = 1'b0;
        vld_out     = 1'b0;
        rdy_upward  = '0;
        dout        = r_dout_hold;

        unique case (r_state)
            IDLE: begin
                if (ap_start) w_state_nxt = ARB;
            end
            ARB: begin
                if (!ap_start) begin
                    w_state_nxt = IDLE;
                end else if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_beat_nxt  = '0;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy    = 1'b1;
                vld_out = w_vld_g;
                dout    = w_slice;
                for (int i = 0; i < NUM_REQ; i++) begin
                    rdy_upward[i] = rdy_downward && (r_grant == IDX_W'(i));
                end
                // A dropped valid ends the grant early; ap_start low only
                // takes effect once the grant has ended.
                if (!w_vld_g) begin
                    w_last_nxt  = r_grant;
                    w_state_nxt = ap_start ? ARB : IDLE;
                end else if (w_xfer) begin
                    if (r_beat == LAST_BEAT) begin
                        w_last_nxt  = r_grant;
                        w_state_nxt = ap_start ? ARB : IDLE;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, grant bookkeeping and held output word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_last      <= LAST_REQ;
            r_beat      <= '0;
            r_dout_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_beat  <= w_beat_nxt;
            if (r_state == BUSY) r_dout_hold <= w_slice;
        end
    end

`ifdef OUT_ARB_BEAT_CNT_EN
    logic [BEAT_CNT_W-1:0] r_beat_cnt;

    // Free-running transfer count, wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt <= '0;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif

endmodule
